// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and line levels.
// Also used by the baud-rate-capable transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // Offset of the first (start-bit) sample from the detect cycle.
  function automatic int unsigned uart_half(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit timer: strobes HALF cycles after a load, then every CLKS_PER_BIT cycles.
// The strobe for the load cycle itself (HALF = 0) is left to the caller.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_tick_c
);

  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF = uart_half(CLKS_PER_BIT);
  localparam int unsigned LAST = CLKS_PER_BIT - 1;
  // Preload so the counter reaches LAST exactly HALF cycles after the load cycle.
  localparam int unsigned LOAD = (CLKS_PER_BIT - HALF) % CLKS_PER_BIT;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(LOAD);
    end else if (r_cnt == CW'(LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick_c = (r_cnt == CW'(LAST));

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with a single-entry valid/ready holding register,
// framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miso,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int unsigned HALF = uart_half(CLKS_PER_BIT);
  localparam int unsigned BCW  = $clog2(UART_DATA_BITS);

  uart_state_e               r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [BCW-1:0]            r_bit_idx;

  logic w_tick;
  logic w_start_det;
  logic w_good_stop;
  logic w_bad_stop;

  assign w_start_det = (r_state == ST_IDLE) && (miso != UART_LINE_IDLE);
  assign w_good_stop = (r_state == ST_STOP) && w_tick && (miso == UART_LINE_IDLE);
  assign w_bad_stop  = (r_state == ST_STOP) && w_tick && (miso != UART_LINE_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_start_det),
    .o_tick_c(w_tick)
  );

  // Frame sequencer; with HALF = 0 the start bit is confirmed in the detect cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_WAIT_HIGH;
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else begin
      unique case (r_state)
        ST_WAIT_HIGH: begin
          if (miso == UART_LINE_IDLE) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_start_det) begin
            r_bit_idx <= '0;
            r_state   <= (HALF == 0) ? ST_DATA : ST_START;
          end
        end
        ST_START: begin
          if (w_tick) r_state <= (miso == UART_LINE_IDLE) ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= {miso, r_shift[UART_DATA_BITS-1:1]};
            if (r_bit_idx == BCW'(UART_DATA_BITS - 1)) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BCW'(1);
            end
          end
        end
        ST_STOP: begin
          if (w_tick) r_state <= (miso == UART_LINE_IDLE) ? ST_IDLE : ST_WAIT_HIGH;
        end
        default: r_state <= ST_WAIT_HIGH;
      endcase
    end
  end

  // Holding register: a consume and a new load may share one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= w_bad_stop;
      overrun   <= 1'b0;
      if (w_good_stop) begin
        if (!data_valid || data_ready) begin
          data       <= r_shift;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: two instances (one and four clocks per bit) driven
// by a bench-side line generator; an event-level model predicts loads, overruns, framing errors.
module tb_uart_rx;

  localparam int KIND_LOAD = 0;
  localparam int KIND_FERR = 1;
  localparam int KIND_OVR  = 2;

  typedef struct {
    int         i;
    int         tc;
    logic [7:0] b;
    bit         good;
  } pend_t;

  typedef struct {
    int         i;
    int         kind;
    int         at;
    logic [7:0] b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      miso_v = 2'b11;
  logic [1:0]      rdy_v = 2'b11;
  logic [1:0][7:0] data_v;
  logic [1:0]      valid_v;
  logic [1:0]      ferr_v;
  logic [1:0]      ovr_v;

  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    last_t0 = 0;
  bit    rand_on = 1'b0;
  int    rand_i = 0;
  pend_t pend_q[$];
  exp_t  exp_q[$];
  bit    m_full[2];
  logic  pv[2];
  logic  pr[2];

  uart_rx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .miso      (miso_v[0]),
    .data      (data_v[0]),
    .data_valid(valid_v[0]),
    .data_ready(rdy_v[0]),
    .frame_err (ferr_v[0]),
    .overrun   (ovr_v[0])
  );

  uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .miso      (miso_v[1]),
    .data      (data_v[1]),
    .data_valid(valid_v[1]),
    .data_ready(rdy_v[1]),
    .frame_err (ferr_v[1]),
    .overrun   (ovr_v[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cpb_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, i, cyc, act, exp);
    end
  endtask

  task automatic sb_observe(input int i, input int kind, input logic [7:0] b);
    int   idx;
    exp_t e;
    idx = -1;
    foreach (exp_q[k]) if (idx < 0 && exp_q[k].i == i) idx = k;
    if (idx < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected dut%0d cycle %0d: got event kind %0d data 0x%0h, expected none",
               i, cyc, kind, b);
    end else begin
      e = exp_q[idx];
      exp_q.delete(idx);
      check("sb_kind", i, kind, e.kind);
      check("sb_cycle", i, cyc, e.at);
      if (e.kind == KIND_LOAD) check("sb_data", i, b, e.b);
    end
  endtask

  // Spec-level model: one-entry holding register updated at each stop-sample cycle.
  task automatic model_step(input int i);
    int    idx;
    pend_t p;
    if (rst) begin
      m_full[i] = 1'b0;
      for (int k = pend_q.size() - 1; k >= 0; k--) if (pend_q[k].i == i) pend_q.delete(k);
    end else begin
      idx = -1;
      foreach (pend_q[k]) if (idx < 0 && pend_q[k].i == i && pend_q[k].tc == cyc) idx = k;
      if (idx >= 0 && pend_q[idx].good) begin
        p = pend_q[idx];
        pend_q.delete(idx);
        if (!m_full[i] || rdy_v[i]) begin
          exp_q.push_back('{i, KIND_LOAD, cyc + 1, p.b});
          m_full[i] = 1'b1;
        end else begin
          exp_q.push_back('{i, KIND_OVR, cyc + 1, 8'h00});
        end
      end else begin
        if (idx >= 0) begin
          pend_q.delete(idx);
          exp_q.push_back('{i, KIND_FERR, cyc + 1, 8'h00});
        end
        if (m_full[i] && rdy_v[i]) m_full[i] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid_v[i] === 1'b1 && (pv[i] !== 1'b1 || pr[i] === 1'b1)) sb_observe(i, KIND_LOAD, data_v[i]);
      if (ferr_v[i] === 1'b1) sb_observe(i, KIND_FERR, 8'h00);
      if (ovr_v[i] === 1'b1) sb_observe(i, KIND_OVR, 8'h00);
      pv[i] = valid_v[i];
      pr[i] = rdy_v[i];
      model_step(i);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc != n) @(negedge clk);
  endtask

  task automatic set_rdy(input int i, input logic v);
    @(posedge clk); #1;
    rdy_v[i] = v;
  endtask

  task automatic line_hold(input int i, input logic v, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      miso_v[i] = v;
    end
  endtask

  // Drives one frame; rst_k >= 0 pulses reset in the first cycle of bit k.
  task automatic send_frame(input int i, input logic [7:0] b, input bit stop_ok, input bit expect_rx,
                            input int rst_k, input bit rdy_on_stop);
    int         c;
    int         half;
    logic [9:0] fr;
    c    = cpb_of(i);
    half = (c - 1) / 2;
    fr   = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < c; j++) begin
        @(posedge clk); #1;
        miso_v[i] = fr[k];
        rst = (k == rst_k && j == 0);
        if (k == 9 && j == half && rdy_on_stop) rdy_v[i] = 1'b1;
        if (k == 0 && j == 0) begin
          last_t0 = cyc;
          if (expect_rx) pend_q.push_back('{i, cyc + half + 9 * c, b, stop_ok});
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    int   gap;
    bit   good;
    logic [7:0] b;

    wait_cyc(3);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_data", i, data_v[i], 0);
      check("reset_valid", i, valid_v[i], 0);
      check("reset_ferr", i, ferr_v[i], 0);
      check("reset_ovr", i, ovr_v[i], 0);
    end

    // Loopback timing: start bit first seen at cycle 11, byte visible at cycle 21 only.
    wait_cyc(10);
    send_frame(0, 8'hA5, 1'b1, 1'b1, -1, 1'b0);
    wait_cyc(21);
    check("loop_valid", 0, valid_v[0], 1);
    check("loop_data", 0, data_v[0], 32'hA5);
    wait_cyc(22);
    check("loop_valid_drop", 0, valid_v[0], 0);

    // Back-to-back with consumer stalled.
    set_rdy(0, 1'b0);
    line_hold(0, 1'b1, 2);
    send_frame(0, 8'h01, 1'b1, 1'b1, -1, 1'b0);
    send_frame(0, 8'hFF, 1'b1, 1'b1, -1, 1'b0);
    line_hold(0, 1'b1, 3);
    @(negedge clk);
    check("b2b_data_kept", 0, data_v[0], 32'h01);
    check("b2b_valid_held", 0, valid_v[0], 1);
    set_rdy(0, 1'b1);
    @(negedge clk);
    check("b2b_valid_at_accept", 0, valid_v[0], 1);
    set_rdy(0, 1'b0);
    @(negedge clk);
    check("b2b_valid_cleared", 0, valid_v[0], 0);

    // Same-edge consume and load.
    send_frame(0, 8'h34, 1'b1, 1'b1, -1, 1'b0);
    line_hold(0, 1'b1, 2);
    send_frame(0, 8'h12, 1'b1, 1'b1, -1, 1'b1);
    @(posedge clk); #1;
    rdy_v[0]  = 1'b0;
    miso_v[0] = 1'b1;
    @(negedge clk);
    check("same_edge_data", 0, data_v[0], 32'h12);
    check("same_edge_valid", 0, valid_v[0], 1);
    check("same_edge_ovr", 0, ovr_v[0], 0);

    // Framing error, line held low, then recovery.
    set_rdy(0, 1'b1);
    line_hold(0, 1'b1, 2);
    send_frame(0, 8'h3C, 1'b0, 1'b1, -1, 1'b0);
    t0 = last_t0;
    wait_cyc(t0 + 10);
    check("ferr_pulse", 0, ferr_v[0], 1);
    check("ferr_no_valid", 0, valid_v[0], 0);
    wait_cyc(t0 + 11);
    check("ferr_one_cycle", 0, ferr_v[0], 0);
    line_hold(0, 1'b0, 12);
    line_hold(0, 1'b1, 2);
    send_frame(0, 8'h55, 1'b1, 1'b1, -1, 1'b0);
    line_hold(0, 1'b1, 3);

    // Reset during data bit 3 of 0xC3 (line low), then a clean 0x7E.
    set_rdy(0, 1'b0);
    send_frame(0, 8'h99, 1'b1, 1'b1, -1, 1'b0);
    line_hold(0, 1'b1, 2);
    send_frame(0, 8'hC3, 1'b1, 1'b0, 4, 1'b0);
    @(negedge clk);
    check("rst_data", 0, data_v[0], 0);
    check("rst_valid", 0, valid_v[0], 0);
    check("rst_ferr", 0, ferr_v[0], 0);
    set_rdy(0, 1'b1);
    line_hold(0, 1'b1, 2);
    send_frame(0, 8'h7E, 1'b1, 1'b1, -1, 1'b0);
    line_hold(0, 1'b1, 3);

    // False start at four clocks per bit, then 0x81.
    line_hold(1, 1'b1, 3);
    line_hold(1, 1'b0, 1);
    line_hold(1, 1'b1, 4);
    @(negedge clk);
    check("glitch_no_valid", 1, valid_v[1], 0);
    check("glitch_no_ferr", 1, ferr_v[1], 0);
    send_frame(1, 8'h81, 1'b1, 1'b1, -1, 1'b0);
    line_hold(1, 1'b1, 4);

    // Randomized frames, stop bits and consumer stalls.
    for (int i = 0; i < 2; i++) begin
      rand_i  = i;
      rand_on = 1'b1;
      fork
        begin
          while (rand_on) begin
            @(posedge clk); #1;
            rdy_v[rand_i] = 1'($urandom_range(0, 1));
          end
        end
      join_none
      for (int n = 0; n < ((i == 0) ? 40 : 15); n++) begin
        b    = 8'($urandom);
        good = ($urandom_range(0, 7) != 0);
        send_frame(i, b, good, 1'b1, -1, 1'b0);
        gap = $urandom_range(good ? 0 : 1, 3);
        line_hold(i, 1'b1, gap);
      end
      rand_on = 1'b0;
      line_hold(i, 1'b1, 2);
      rdy_v[i] = 1'b1;
      line_hold(i, 1'b1, 60);
    end

    check("exp_queue_empty", 0, exp_q.size(), 0);
    check("pend_queue_empty", 0, pend_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
